// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: one outstanding single-word read, PC increment on a clean completion,
// and a small prefetch queue of {address, word} pairs for decode. Any PC redirect flushes the queue.
module fetch_unit #(
   parameter int DEPTH = 2,
   parameter int AW    = 16,
   parameter int DW    = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [AW-1:0] pc_val,
   output logic          pc_inc,
   input  logic          redirect,
   input  logic          hold,
   output logic          mem_req,
   output logic [AW-1:0] mem_addr,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_ack,
   output logic          ir_valid,
   output logic [DW-1:0] ir_out,
   output logic [AW-1:0] ir_pc,
   input  logic          ir_take
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   count_q, count_d;
   logic [PW-1:0]   rd_q, rd_d, wr_q, wr_d;
   logic            mem_req_q, mem_req_d;
   logic [AW-1:0]   mem_addr_q, mem_addr_d;
   logic [DW-1:0]   data_q [DEPTH];
   logic [DW-1:0]   data_d [DEPTH];
   logic [AW-1:0]   addr_q [DEPTH];
   logic [AW-1:0]   addr_d [DEPTH];
   logic            push, pop;

   always_comb begin
      state_d    = state_q;
      mem_req_d  = mem_req_q;
      mem_addr_d = mem_addr_q;
      rd_d       = rd_q;
      wr_d       = wr_q;
      count_d    = count_q;
      data_d     = data_q;
      addr_d     = addr_q;
      push       = 1'b0;

      case (state_q)
         IDLE: begin
            if (count_q < FULL && !hold && !redirect) begin
               mem_req_d  = 1'b1;
               mem_addr_d = pc_val;
               state_d    = REQ;
            end
         end
         REQ: begin
            if (mem_ack) begin
               mem_req_d = 1'b0;
               state_d   = IDLE;
               push      = !redirect;
            end else if (redirect) begin
               state_d = DISCARD;
            end
         end
         DISCARD: begin
            // The bus transaction must still finish; its data belongs to the old stream.
            if (mem_ack) begin
               mem_req_d = 1'b0;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      pop = ir_take && (count_q != '0) && !redirect;

      if (push) begin
         data_d[wr_q] = mem_rdata;
         addr_d[wr_q] = mem_addr_q;
         wr_d         = wr_q + PW'(1);
      end
      if (pop) rd_d = rd_q + PW'(1);

      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      if (redirect) begin
         count_d = '0;
         rd_d    = '0;
         wr_d    = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         count_q    <= '0;
         rd_q       <= '0;
         wr_q       <= '0;
         mem_req_q  <= 1'b0;
         mem_addr_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            data_q[i] <= '0;
            addr_q[i] <= '0;
         end
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         rd_q       <= rd_d;
         wr_q       <= wr_d;
         mem_req_q  <= mem_req_d;
         mem_addr_q <= mem_addr_d;
         data_q     <= data_d;
         addr_q     <= addr_d;
      end
   end

   assign pc_inc   = push && !rst;
   assign mem_req  = mem_req_q;
   assign mem_addr = mem_addr_q;
   assign ir_valid = (count_q != '0);
   assign ir_out   = data_q[rd_q];
   assign ir_pc    = addr_q[rd_q];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed scenarios plus a randomized run, checked every cycle against a transaction-level model
// (queue of {addr,word}, one outstanding-fetch flag, a drop flag) and a behavioural PC.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] pc_val = '0;
   logic        pc_inc;
   logic        redirect = 1'b0;
   logic        hold = 1'b0;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic [15:0] mem_rdata = '0;
   logic        mem_ack = 1'b0;
   logic        ir_valid;
   logic [15:0] ir_out;
   logic [15:0] ir_pc;
   logic        ir_take = 1'b0;

   always #5 clk = ~clk;

   fetch_unit #(.DEPTH(2), .AW(16), .DW(16)) dut (
      .clk(clk), .rst(rst), .pc_val(pc_val), .pc_inc(pc_inc), .redirect(redirect),
      .hold(hold), .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .mem_ack(mem_ack), .ir_valid(ir_valid), .ir_out(ir_out), .ir_pc(ir_pc),
      .ir_take(ir_take)
   );

   int checks = 0;
   int errors = 0;

   logic [31:0] mq[$];
   bit          m_out  = 1'b0;
   bit          m_drop = 1'b0;
   logic [15:0] m_addr = '0;
   logic [15:0] pc     = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs();
      chk("mem_req", {31'd0, mem_req}, {31'd0, m_out});
      chk("mem_addr", {16'd0, mem_addr}, {16'd0, m_addr});
      chk("ir_valid", {31'd0, ir_valid}, {31'd0, mq.size() != 0});
      if (mq.size() != 0) begin
         chk("ir_pc", {16'd0, ir_pc}, {16'd0, mq[0][31:16]});
         chk("ir_out", {16'd0, ir_out}, {16'd0, mq[0][15:0]});
      end
   endtask

   // am: 0 = no ack, 1 = ack, 2 = ack whenever a request is up
   task automatic cycle(input bit r, input bit h, input bit t, input int am, input logic [15:0] npc);
      bit exp_inc;
      int sz;
      @(negedge clk);
      rst       = 1'b0;
      redirect  = r;
      hold      = h;
      ir_take   = t;
      pc_val    = pc;
      mem_ack   = (am == 2) ? mem_req : (am == 1);
      mem_rdata = mem_addr ^ 16'hA5A5;
      #1;
      exp_inc = m_out && !m_drop && mem_ack && !r;
      check_outputs();
      chk("pc_inc", {31'd0, pc_inc}, {31'd0, exp_inc});
      @(posedge clk);
      sz = mq.size();
      if (r) mq.delete();
      else begin
         if (t && sz > 0) void'(mq.pop_front());
         if (exp_inc) mq.push_back({m_addr, m_addr ^ 16'hA5A5});
      end
      if (m_out) begin
         if (mem_ack) begin
            m_out  = 1'b0;
            m_drop = 1'b0;
         end else if (r) m_drop = 1'b1;
      end else if (sz < 2 && !h && !r) begin
         m_out  = 1'b1;
         m_addr = pc;
      end
      if (r) pc = npc;
      else if (exp_inc) pc = pc + 16'd1;
   endtask

   task automatic reset_cycle(input bit a);
      @(negedge clk);
      rst      = 1'b1;
      redirect = 1'($urandom_range(0, 1));
      hold     = 1'($urandom_range(0, 1));
      ir_take  = 1'($urandom_range(0, 1));
      mem_ack  = a;
      pc_val   = pc;
      #1;
      chk("pc_inc_in_rst", {31'd0, pc_inc}, 32'd0);
      @(posedge clk);
      mq.delete();
      m_out  = 1'b0;
      m_drop = 1'b0;
      m_addr = '0;
      pc     = '0;
      #1;
      chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
      chk("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
      chk("rst_ir_valid", {31'd0, ir_valid}, 32'd0);
      chk("rst_ir_out", {16'd0, ir_out}, 32'd0);
      chk("rst_ir_pc", {16'd0, ir_pc}, 32'd0);
   endtask

   initial begin
      reset_cycle(1'b0);
      reset_cycle(1'b0);

      // Free-run from address 0 with single-cycle acks.
      cycle(0, 0, 0, 2, 16'h0);
      cycle(0, 0, 0, 2, 16'h0);
      #2;
      chk("first_ir_valid", {31'd0, ir_valid}, 32'd1);
      chk("first_ir_pc", {16'd0, ir_pc}, 32'h0000);
      chk("first_ir_out", {16'd0, ir_out}, 32'hA5A5);
      for (int i = 0; i < 20; i++) cycle(0, 0, 1, 2, 16'h0);

      // Back-pressure: queue fills with addresses 0 and 1, then fetching stops.
      cycle(1, 0, 0, 2, 16'h0000);
      for (int i = 0; i < 12; i++) cycle(0, 0, 0, 2, 16'h0);
      #2;
      chk("bp_stalled", {31'd0, mem_req}, 32'd0);
      chk("bp_head", {16'd0, ir_pc}, 32'h0000);
      cycle(0, 0, 1, 0, 16'h0);
      #2;
      chk("bp_head_after_take", {16'd0, ir_pc}, 32'h0001);
      cycle(0, 0, 0, 0, 16'h0);
      #2;
      chk("bp_next_req", {31'd0, mem_req}, 32'd1);
      chk("bp_next_addr", {16'd0, mem_addr}, 32'h0002);

      // Redirect while a slow fetch is outstanding.
      cycle(1, 0, 1, 2, 16'h0000);
      cycle(0, 0, 1, 0, 16'h0);
      cycle(1, 0, 1, 0, 16'hFFF0);
      cycle(0, 0, 1, 0, 16'h0);
      cycle(0, 0, 1, 0, 16'h0);
      cycle(0, 0, 1, 1, 16'h0);
      #2;
      chk("disc_empty", {31'd0, ir_valid}, 32'd0);
      cycle(0, 0, 1, 2, 16'h0);
      #2;
      chk("disc_next_addr", {16'd0, mem_addr}, 32'hFFF0);
      for (int i = 0; i < 8; i++) cycle(0, 0, 1, 2, 16'h0);

      // Redirect coinciding with ack and take while one entry is queued.
      cycle(1, 0, 0, 2, 16'h0100);
      cycle(0, 0, 0, 2, 16'h0);
      cycle(0, 0, 0, 2, 16'h0);
      cycle(0, 0, 0, 0, 16'h0);
      cycle(1, 0, 1, 1, 16'h0200);
      #2;
      chk("coinc_flushed", {31'd0, ir_valid}, 32'd0);
      cycle(0, 0, 0, 2, 16'h0);
      #2;
      chk("coinc_next_addr", {16'd0, mem_addr}, 32'h0200);

      // Hold raised during a fetch: it completes, then nothing new until hold drops.
      cycle(0, 1, 1, 0, 16'h0);
      cycle(0, 1, 0, 1, 16'h0);
      for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, 16'h0);
      #2;
      chk("hold_no_req", {31'd0, mem_req}, 32'd0);
      chk("hold_pushed", {16'd0, ir_pc}, 32'h0200);
      cycle(0, 0, 0, 0, 16'h0);
      #2;
      chk("hold_next_addr", {16'd0, mem_addr}, 32'h0201);

      // Reset mid-fetch with an entry queued, then a stale ack.
      reset_cycle(1'b0);
      cycle(0, 0, 0, 1, 16'h0);
      #2;
      chk("late_ack_ignored", {31'd0, ir_valid}, 32'd0);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 199) == 0) reset_cycle(1'($urandom_range(0, 1)));
         else cycle(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) == 0),
                    1'($urandom_range(0, 1)), int'($urandom_range(0, 1)), 16'($urandom));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
